// File: rtl/e_mdu_issue_if.sv
// ---------------------------------------------------------------------------
// e_mdu_issue_if
//   Handshake between the E-stage MDU issue controller and e_mdu.
//
//   mdu_start  issuer -> e_mdu  one-cycle start pulse for mult/multu/div/divu
//   mdu_op     issuer -> e_mdu  MDU operation code (0 = none)
//   mdu_d1     issuer -> e_mdu  first operand (rs)
//   mdu_d2     issuer -> e_mdu  second operand (rt)
//   mdu_busy   e_mdu -> issuer  long operation in progress
//
//   master: the issue controller; slave: the multiply/divide unit.
// ---------------------------------------------------------------------------
interface e_mdu_issue_if;
  logic        mdu_start;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_d1;
  logic [31:0] mdu_d2;
  logic        mdu_busy;

  modport master (
    output mdu_start,
    output mdu_op,
    output mdu_d1,
    output mdu_d2,
    input  mdu_busy
  );

  modport slave (
    input  mdu_start,
    input  mdu_op,
    input  mdu_d1,
    input  mdu_d2,
    output mdu_busy
  );
endinterface

// File: rtl/e_mdu_issue.sv
// ---------------------------------------------------------------------------
// e_mdu_issue
//   E-stage initiator for the multiply/divide unit. Gates each MDU operation
//   against a CP0 flush, drives the start/op/operand handshake to e_mdu,
//   tracks the in-flight operation across the start-to-busy gap, stalls
//   dependent D-stage MDU instructions, watches busy for a hang and counts
//   launched operations.
//
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   e_valid     in   E-stage instruction valid
//   e_op        in   MDU class: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                    6 mtlo, anything else = none
//   e_rs, e_rt  in   forwarded operands
//   req         in   CP0 flush request; the E instruction must not act
//   d_uses_mdu  in   D-stage instruction touches the MDU
//   mdu         if   master side of the e_mdu handshake
//   stall_d     out  stall request for D stage
//   inflight    out  operation launched and not yet finished
//   err         out  sticky busy-watchdog error
//   issue_cnt   out  launched mult/div operations (wraps)
// ---------------------------------------------------------------------------
module e_mdu_issue #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 e_valid,
  input  logic [3:0]           e_op,
  input  logic [31:0]          e_rs,
  input  logic [31:0]          e_rt,
  input  logic                 req,
  input  logic                 d_uses_mdu,
  e_mdu_issue_if.master        mdu,
  output logic                 stall_d,
  output logic                 inflight,
  output logic                 err,
  output logic [CNT_W-1:0]     issue_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam int                  WCNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0]   WAIT_MAX  = WCNT_W'(MAX_WAIT);
  localparam logic [WCNT_W-1:0]   WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

  state_t             r_state;
  logic               r_launch_ext;   // LAUNCH already extended by one cycle
  logic [WCNT_W-1:0]  r_wait_cnt;
  logic               r_err;
  logic [CNT_W-1:0]   r_issue_cnt;

  logic w_gate;
  logic w_known_op;
  logic w_start;

  // Only an idle controller accepts a new E-stage op, and a flush request
  // cancels it in the same cycle (flush beats start).
  assign w_gate     = e_valid & ~req & (r_state == S_IDLE);
  assign w_known_op = (e_op >= 4'd1) && (e_op <= 4'd6);
  assign w_start    = w_gate && (e_op >= 4'd1) && (e_op <= 4'd4);

  assign mdu.mdu_op    = (w_gate && w_known_op) ? e_op : 4'd0;
  assign mdu.mdu_start = w_start;
  assign mdu.mdu_d1    = e_rs;
  assign mdu.mdu_d2    = e_rt;

  assign inflight  = (r_state != S_IDLE);
  // mdu_start covers the launch cycle, in which e_mdu has not yet raised busy.
  assign stall_d   = d_uses_mdu & (inflight | w_start | mdu.mdu_busy);
  assign err       = r_err;
  assign issue_cnt = r_issue_cnt;

  // NOTE: state is updated with non-blocking assignments only, so every
  // branch below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_launch_ext <= 1'b0;
      r_wait_cnt   <= '0;
      r_err        <= 1'b0;
      r_issue_cnt  <= '0;
    end else begin
      if (w_start) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_launch_ext <= 1'b0;
          if (w_start) begin
            r_state <= S_LAUNCH;
          end else if (mdu.mdu_busy) begin
            // Busy without our start: follow it until it ends.
            r_state <= S_WAIT;
          end
        end

        S_LAUNCH: begin
          if (mdu.mdu_busy) begin
            r_state      <= S_WAIT;
            r_launch_ext <= 1'b0;
          end else if (!r_launch_ext) begin
            // Tolerate busy rising one cycle late.
            r_launch_ext <= 1'b1;
          end else begin
            r_state      <= S_IDLE;
            r_launch_ext <= 1'b0;
          end
        end

        S_WAIT: begin
          if (mdu.mdu_busy) begin
            if (r_wait_cnt != WAIT_MAX) begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
              if (r_wait_cnt == WAIT_LAST) begin
                r_err <= 1'b1;
              end
            end
          end else begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_launch_ext <= 1'b0;
          r_wait_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu_issue.sv
// ---------------------------------------------------------------------------
// tb_e_mdu_issue
//   Bench for e_mdu_issue: a table of single-op vectors whose expected
//   handshake values pass through a scoreboard queue, followed by hand-written
//   sequences for the start-to-busy gap, spurious busy, the watchdog and
//   reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_e_mdu_issue;

  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             e_valid;
  logic [3:0]       e_op;
  logic [31:0]      e_rs;
  logic [31:0]      e_rt;
  logic             req;
  logic             d_uses_mdu;
  logic             stall_d;
  logic             inflight;
  logic             err;
  logic [CNT_W-1:0] issue_cnt;

  e_mdu_issue_if mdu_if ();

  e_mdu_issue #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .e_valid    (e_valid),
    .e_op       (e_op),
    .e_rs       (e_rs),
    .e_rt       (e_rt),
    .req        (req),
    .d_uses_mdu (d_uses_mdu),
    .mdu        (mdu_if),
    .stall_d    (stall_d),
    .inflight   (inflight),
    .err        (err),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        req;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_start;
    logic [3:0]  exp_op;
  } vec_t;

  typedef struct {
    logic        start;
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cnt_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    e_valid    = 1'b0;
    e_op       = 4'd0;
    e_rs       = 32'd0;
    e_rt       = 32'd0;
    req        = 1'b0;
    d_uses_mdu = 1'b0;
    mdu_if.mdu_busy = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'd1,  32'd3,        32'd5,        1'b1, 4'd1};
    vecs[1]  = '{1'b1, 1'b1, 4'd3,  32'h11,       32'h22,       1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 4'd5,  32'h33,       32'h44,       1'b0, 4'd0};
    vecs[3]  = '{1'b1, 1'b0, 4'd6,  32'hDEADBEEF, 32'h0,        1'b0, 4'd6};
    vecs[4]  = '{1'b1, 1'b0, 4'd5,  32'h1234,     32'h5678,     1'b0, 4'd5};
    vecs[5]  = '{1'b0, 1'b0, 4'd2,  32'h7,        32'h9,        1'b0, 4'd0};
    vecs[6]  = '{1'b1, 1'b0, 4'd9,  32'hA,        32'hB,        1'b0, 4'd0};
    vecs[7]  = '{1'b1, 1'b0, 4'd15, 32'hC,        32'hD,        1'b0, 4'd0};
    vecs[8]  = '{1'b1, 1'b0, 4'd4,  32'hFFFFFFFF, 32'h80000000, 1'b1, 4'd4};
    vecs[9]  = '{1'b1, 1'b0, 4'd2,  32'h0,        32'h1,        1'b1, 4'd2};
    vecs[10] = '{1'b1, 1'b0, 4'd3,  32'h55AA55AA, 32'hAA55AA55, 1'b1, 4'd3};
    vecs[11] = '{1'b1, 1'b0, 4'd7,  32'h1,        32'h2,        1'b0, 4'd0};

    // ---------------- reset state ----------------
    idle_inputs();
    reset = 1'b1;
    #12;
    check("rst_inflight",  inflight,  0);
    check("rst_err",       err,       0);
    check("rst_issue_cnt", issue_cnt, 0);
    check("rst_start",     mdu_if.mdu_start, 0);
    check("rst_stall",     stall_d,   0);
    reset = 1'b0;
    step();

    // ---------------- table vectors ----------------
    for (int i = 0; i < 12; i++) begin
      exp_t e;
      e_valid = vecs[i].valid;
      req     = vecs[i].req;
      e_op    = vecs[i].op;
      e_rs    = vecs[i].rs;
      e_rt    = vecs[i].rt;
      sb.push_back('{vecs[i].exp_start, vecs[i].exp_op, vecs[i].rs, vecs[i].rt});
      #1;
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_start", i), mdu_if.mdu_start, e.start);
        check($sformatf("v%0d_op", i),    mdu_if.mdu_op,    e.op);
        check($sformatf("v%0d_d1", i),    mdu_if.mdu_d1,    e.d1);
        check($sformatf("v%0d_d2", i),    mdu_if.mdu_d2,    e.d2);
      end
      if (vecs[i].exp_start) cnt_model++;
      step();
      check($sformatf("v%0d_inflight", i), inflight, vecs[i].exp_start);
      check($sformatf("v%0d_cnt", i),      issue_cnt, cnt_model);
      if (vecs[i].exp_start) begin
        // E inputs still present during LAUNCH: no second start.
        check($sformatf("v%0d_launch_nostart", i), mdu_if.mdu_start, 0);
        check($sformatf("v%0d_launch_op0", i),     mdu_if.mdu_op,    0);
        e_valid = 1'b0;
        step();
        check($sformatf("v%0d_launch_ext", i), inflight, 1);
        step();
        check($sformatf("v%0d_launch_done", i), inflight, 0);
      end
      idle_inputs();
      step();
    end

    // ---------------- start-to-busy gap ----------------
    e_valid = 1'b1; e_op = 4'd1; e_rs = 32'd7; e_rt = 32'd9; d_uses_mdu = 1'b1;
    #1;
    check("gap_launch_stall", stall_d, 1);
    check("gap_launch_start", mdu_if.mdu_start, 1);
    cnt_model++;
    step();
    e_valid = 1'b0; e_op = 4'd0;
    mdu_if.mdu_busy = 1'b1;
    #1;
    check("gap_next_stall", stall_d, 1);
    check("gap_next_start", mdu_if.mdu_start, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      check($sformatf("gap_busy%0d_stall", j), stall_d, 1);
    end
    mdu_if.mdu_busy = 1'b0;
    step();
    check("gap_end_stall",    stall_d,   0);
    check("gap_end_inflight", inflight,  0);
    check("gap_end_cnt",      issue_cnt, cnt_model);
    idle_inputs();
    step();

    // ---------------- spurious busy ----------------
    mdu_if.mdu_busy = 1'b1;
    #1;
    check("spur_nostart", mdu_if.mdu_start, 0);
    step();
    check("spur_inflight", inflight, 1);
    mdu_if.mdu_busy = 1'b0;
    step();
    check("spur_idle", inflight, 0);
    check("spur_cnt",  issue_cnt, cnt_model);

    // ---------------- watchdog ----------------
    e_valid = 1'b1; e_op = 4'd3;
    #1;
    check("wd_start", mdu_if.mdu_start, 1);
    cnt_model++;
    step();
    e_valid = 1'b0; e_op = 4'd0;
    mdu_if.mdu_busy = 1'b1;
    step();  // now in WAIT
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("wd_err_k%0d", k), err, (k >= MAX_WAIT) ? 1 : 0);
    end
    mdu_if.mdu_busy = 1'b0;
    step();
    check("wd_err_sticky", err, 1);
    check("wd_idle",       inflight, 0);
    #2;
    reset = 1'b1;
    #1;
    check("wd_rst_err", err, 0);
    check("wd_rst_cnt", issue_cnt, 0);
    cnt_model = 0;
    #1;
    reset = 1'b0;
    step();

    // ---------------- reset mid-operation ----------------
    e_valid = 1'b1; e_op = 4'd4;
    step();
    cnt_model++;
    e_valid = 1'b0; e_op = 4'd0;
    mdu_if.mdu_busy = 1'b1;
    step();
    check("mid_inflight_pre", inflight,  1);
    check("mid_cnt_pre",      issue_cnt, cnt_model);
    #2;
    reset = 1'b1;
    mdu_if.mdu_busy = 1'b0;
    d_uses_mdu = 1'b1;
    #1;
    check("mid_rst_inflight", inflight,  0);
    check("mid_rst_stall",    stall_d,   0);
    check("mid_rst_cnt",      issue_cnt, 0);
    #1;
    reset = 1'b0;
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
